// File: rtl/vga_pkg.sv
// Shared VGA timing and colour constants for the memory viewer.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [23:0] FG_DEF   = 24'h00FF00;
    localparam logic [23:0] BG_DEF   = 24'h002000;
    localparam logic [23:0] GRID_DEF = 24'h404040;

    typedef struct packed {
        logic vis;
        logic grid;
        logic on;
        logic act;
        logic hs;
        logic vs;
    } px_s1_t;

    localparam px_s1_t S1_RST = '{
        vis: 1'b0, grid: 1'b0, on: 1'b0,
        act: 1'b0, hs: 1'b1, vs: 1'b1
    };

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters driven by a 25 MHz enable from 50 MHz.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic       pix_en,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       active,
    output logic       hs,
    output logic       vs,
    output logic       line_end,
    output logic       frame_end
);

    logic [9:0] v_nxt;

    assign line_end  = h == 10'(H_TOTAL - 1);
    assign frame_end = line_end && v == 10'(V_TOTAL - 1);

    always_comb begin
        v_nxt = v;
        if (line_end)
            v_nxt = frame_end ? '0 : v + 10'd1;
    end

    // v is rewritten on every tick, not only at line wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en <= 1'b0;
            h      <= '0;
            v      <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                h <= line_end ? '0 : h + 10'd1;
                v <= v_nxt;
            end
        end
    end

    assign active = h < 10'(H_ACTIVE) && v < 10'(V_ACTIVE);
    assign hs = !(h >= 10'(H_ACTIVE + H_FP) &&
                  h <  10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs = !(v >= 10'(V_ACTIVE + V_FP) &&
                  v <  10'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_mem_viewer.sv
// Renders a per-frame snapshot of data memory bytes 0..31 as a bit grid.
module vga_mem_viewer
    import vga_pkg::*;
#(
    parameter int          X_OFF  = 80,
    parameter int          CELL_W = 60,
    parameter int          CELL_H = 15,
    parameter logic [23:0] FG     = FG_DEF,
    parameter logic [23:0] BG     = BG_DEF,
    parameter logic [23:0] GRID   = GRID_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [255:0] memory_first_32_bytes,
    output logic [7:0]   vga_r,
    output logic [7:0]   vga_g,
    output logic [7:0]   vga_b,
    output logic         vga_hs,
    output logic         vga_vs,
    output logic         vga_blank_n,
    output logic         vga_sync_n,
    output logic         vga_clk,
    output logic         frame_start
);

    localparam int CXW = $clog2(CELL_W);
    localparam int CYW = $clog2(CELL_H);
    localparam logic [9:0] GX0 = 10'(X_OFF);
    localparam logic [9:0] GX1 = 10'(X_OFF + 8 * CELL_W);

    logic           pix_en;
    logic [9:0]     h;
    logic [9:0]     v;
    logic           active;
    logic           hs_raw;
    logic           vs_raw;
    logic           line_end;
    logic           frame_end;
    logic           cap;
    logic [255:0]   snap;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [2:0]     col;
    logic [4:0]     row;
    px_s1_t         s1;
    logic [23:0]    rgb;
    logic [23:0]    rgb_nxt;

    vga_timing_gen u_tg (
        .clk       (clk),
        .resetn    (resetn),
        .pix_en    (pix_en),
        .h         (h),
        .v         (v),
        .active    (active),
        .hs        (hs_raw),
        .vs        (vs_raw),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    assign cap         = pix_en && h == '0 && v == 10'(V_ACTIVE);
    assign frame_start = cap;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            snap <= '0;
        else if (cap)
            snap <= memory_first_32_bytes;
    end

    // cx/cy track h/v in step so no divide is needed for the cell index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx  <= '0;
            col <= '0;
            cy  <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (h == GX0 - 10'd1) begin
                cx  <= '0;
                col <= '0;
            end else if (cx == CXW'(CELL_W - 1)) begin
                cx  <= '0;
                col <= col + 3'd1;
            end else begin
                cx <= cx + CXW'(1);
            end
            if (frame_end) begin
                cy  <= '0;
                row <= '0;
            end else if (line_end) begin
                if (cy == CYW'(CELL_H - 1)) begin
                    cy  <= '0;
                    row <= row + 5'd1;
                end else begin
                    cy <= cy + CYW'(1);
                end
            end
        end
    end

    // byte n bit b lives at 255-8n-(7-b), i.e. the inverted {row,col}
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= S1_RST;
        end else if (pix_en) begin
            s1.vis  <= active && h >= GX0 && h < GX1;
            s1.grid <= cx == '0 || cy == '0;
            s1.on   <= snap[~{row, col}];
            s1.act  <= active;
            s1.hs   <= hs_raw;
            s1.vs   <= vs_raw;
        end
    end

    always_comb begin
        rgb_nxt = '0;
        if (!s1.vis)
            rgb_nxt = '0;
        else if (s1.grid)
            rgb_nxt = GRID;
        else if (s1.on)
            rgb_nxt = FG;
        else
            rgb_nxt = BG;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb         <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_clk     <= 1'b0;
        end else begin
            vga_clk <= pix_en;
            if (pix_en) begin
                rgb         <= rgb_nxt;
                vga_hs      <= s1.hs;
                vga_vs      <= s1.vs;
                vga_blank_n <= s1.act;
            end
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb;
    assign vga_sync_n            = 1'b0;

endmodule

// File: tb/tb_vga_mem_viewer.sv
// Directed bench for vga_mem_viewer: sync timing, snapshot, pixel map.
module tb_vga_mem_viewer;

    typedef struct {
        int          x;
        int          y;
        logic [24:0] exp;
    } vec_t;

    localparam logic [24:0] OFF = 25'h0000000;
    localparam logic [24:0] BLK = 25'h1000000;
    localparam logic [24:0] GRV = {1'b1, 24'h404040};
    localparam logic [24:0] FGV = {1'b1, 24'h00FF00};
    localparam logic [24:0] BGV = {1'b1, 24'h002000};

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [255:0] mem;
    logic [7:0]   vga_r;
    logic [7:0]   vga_g;
    logic [7:0]   vga_b;
    logic         vga_hs;
    logic         vga_vs;
    logic         vga_blank_n;
    logic         vga_sync_n;
    logic         vga_clk;
    logic         frame_start;

    int n_chk = 0;
    int n_err = 0;
    int clk_cnt = 0;
    vec_t tab[19];

    vga_mem_viewer dut (
        .clk                   (clk),
        .resetn                (resetn),
        .memory_first_32_bytes (mem),
        .vga_r                 (vga_r),
        .vga_g                 (vga_g),
        .vga_b                 (vga_b),
        .vga_hs                (vga_hs),
        .vga_vs                (vga_vs),
        .vga_blank_n           (vga_blank_n),
        .vga_sync_n            (vga_sync_n),
        .vga_clk               (vga_clk),
        .frame_start           (frame_start)
    );

    always #10 clk = ~clk;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    function automatic logic [31:0] pins();
        return {2'b00, vga_r, vga_g, vga_b, vga_hs, vga_vs,
                vga_blank_n, vga_sync_n, vga_clk, frame_start};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // pixel k after the capture tick shows on the pins after edge base+3+2k
    task automatic goto_k(input int base, input int k);
        int tgt;
        tgt = base + 3 + 2 * k;
        while (clk_cnt < tgt) @(negedge clk);
        if (clk_cnt != tgt) check("goto_overshoot", clk_cnt, tgt);
    endtask

    task automatic release_and_time_hs(input string nm);
        int c0;
        int hi;
        resetn = 1'b1;
        c0 = clk_cnt;
        hi = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (vga_clk) hi++;
            if (!vga_hs) break;
        end
        check(nm, clk_cnt - c0, 1316);
        check("vga_clk_highs", hi, 658);
    endtask

    task automatic wait_hs_fall(output bit ok);
        bit prev;
        prev = vga_hs;
        ok = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (prev && !vga_hs) begin
                ok = 1'b1;
                break;
            end
            prev = vga_hs;
        end
    endtask

    // jump to line 479, catch the capture, then jump to 488 or 523
    task capture(input bit to488, output int base);
        bit ok;
        wait_hs_fall(ok);
        check("hs_fall_found", 32'(ok), 1);
        force dut.u_tg.v = 10'd479;
        repeat (4) @(negedge clk);
        release dut.u_tg.v;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_start_found", 32'(ok), 1);
        base = clk_cnt;
        @(negedge clk);
        check("frame_start_width", 32'(frame_start), 0);
        if (to488)
            force dut.u_tg.v = 10'd488;
        else
            force dut.u_tg.v = 10'd523;
        repeat (4) @(negedge clk);
        release dut.u_tg.v;
    endtask

    initial begin
        int base;
        int lows;

        tab[0]  = '{300, -2, OFF};
        tab[1]  = '{81, 0, GRV};
        tab[2]  = '{79, 1, BLK};
        tab[3]  = '{81, 1, FGV};
        tab[4]  = '{141, 1, BGV};
        tab[5]  = '{501, 1, BGV};
        tab[6]  = '{560, 1, BLK};
        tab[7]  = '{559, 2, BGV};
        tab[8]  = '{640, 3, OFF};
        tab[9]  = '{700, 3, OFF};
        tab[10] = '{80, 5, GRV};
        tab[11] = '{81, 14, FGV};
        tab[12] = '{200, 15, GRV};
        tab[13] = '{81, 16, BGV};
        tab[14] = '{141, 16, FGV};
        tab[15] = '{201, 16, BGV};
        tab[16] = '{261, 16, FGV};
        tab[17] = '{441, 16, FGV};
        tab[18] = '{501, 16, BGV};

        mem = {8{32'hA5C3_F00F}};
        repeat (3) @(negedge clk);
        check("reset_pins", pins(), 32'h30);

        mem = '0;
        mem[255:248] = 8'h80;
        mem[247:240] = 8'h5A;
        mem[7:0]     = 8'h01;
        release_and_time_hs("hs_first_low");

        lows = 0;
        for (int i = 0; i < 1600; i++) begin
            if (!vga_hs) lows++;
            @(negedge clk);
        end
        check("hs_low_ticks", lows, 192);
        check("hs_next_fall", 32'(vga_hs), 0);
        check("vs_idle", 32'(vga_vs), 1);

        capture(1'b0, base);
        mem = '0;
        foreach (tab[i]) begin
            goto_k(base, (2 + tab[i].y) * 800 + tab[i].x);
            check($sformatf("pix(%0d,%0d)", tab[i].x, tab[i].y),
                  32'({vga_blank_n, vga_r, vga_g, vga_b}),
                  32'(tab[i].exp));
        end

        capture(1'b0, base);
        goto_k(base, 2 * 800 + 81);
        check("new_snap_grid", 32'({vga_blank_n, vga_r, vga_g, vga_b}),
              32'(GRV));
        goto_k(base, 3 * 800 + 81);
        check("new_snap_byte0", 32'({vga_blank_n, vga_r, vga_g, vga_b}),
              32'(BGV));

        resetn = 1'b0;
        #1;
        check("midframe_reset", pins(), 32'h30);
        repeat (3) @(negedge clk);
        release_and_time_hs("hs_first_low_2");

        capture(1'b1, base);
        goto_k(base, 1599);
        check("vs_before", 32'(vga_vs), 1);
        goto_k(base, 1600);
        check("vs_fall", 32'(vga_vs), 0);
        goto_k(base, 3199);
        check("vs_last_low", 32'(vga_vs), 0);
        goto_k(base, 3200);
        check("vs_rise", 32'(vga_vs), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_mem_viewer.md
# vga_mem_viewer

Downstream consumer of the memory stage's 256-bit `memory_first_32_bytes` snapshot. Renders bytes 0–31 of data memory as a 32-row × 8-column bit grid on a 640×480@60 Hz VGA output, one row per byte and MSB on the left. It generates its own pixel enable and sync timing. It captures the input once per frame so the picture never tears mid-frame.

## Interface
Parameters:
- `X_OFF`, default 80: left edge of the grid, in pixels.
- `CELL_W`, default 60: cell width, in pixels; 8 × 60 = 480.
- `CELL_H`, default 15: cell height, in pixels; 32 × 15 = 480.
- `FG`, default 24'h00FF00: colour for a bit value of 1.
- `BG`, default 24'h002000: colour for a bit value of 0.
- `GRID`, default 24'h404040: cell border colour.

Ports:
- `clk` in 1: 50 MHz system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `memory_first_32_bytes` in 256: byte n occupies bits [255-8n : 248-8n].
- `vga_r`, `vga_g`, `vga_b` out 8 each: pixel colour.
- `vga_hs` out 1: horizontal sync, active-low.
- `vga_vs` out 1: vertical sync, active-low.
- `vga_blank_n` out 1: high during the active area.
- `vga_sync_n` out 1: constant 0.
- `vga_clk` out 1: registered copy of the pixel enable.
- `frame_start` out 1: one-`clk` pulse when the snapshot is captured.

## Operation
- **Pixel enable.** `pix_en` toggles every `clk`, giving 25 MHz. All counters advance only when `pix_en`=1.
- **Horizontal counter `h`.** Runs 0..799.
  - 0..639 active.
  - 640..655 front porch.
  - 656..751 sync.
  - 752..799 back porch.
- **Vertical counter `v`.** Runs 0..524 and increments when `h` wraps from 799 to 0.
  - 0..479 active.
  - 480..489 front porch.
  - 490..491 sync.
  - 492..524 back porch.
- **Snapshot.** `snap` (256 bits) loads from `memory_first_32_bytes` on the `pix_en` tick where `h`=0 and `v`=480. `frame_start` pulses in that same cycle. Input changes at any other time are invisible until the next load.
- **Cell sub-counters (no dividers).**
  - `cx` (0..CELL_W-1) and `col` (0..7) reset when `h`=X_OFF-1. `cx` then increments with `h` and wraps to 0, incrementing `col`.
  - `cy` (0..CELL_H-1) and `row` (0..31) reset at `v`=524→0. `cy` then increments per line and wraps to 0, incrementing `row`.
- **Colour selection**, evaluated in priority order:
  - not active, or `h`<X_OFF, or `h`≥X_OFF+480 → black;
  - `cx`=0 or `cy`=0 → GRID;
  - `snap` bit [255-8·row-col]=1 → FG;
  - otherwise → BG.
- **Reset.**
  - `h`, `v`, `cx`, `cy`, `row`, `col` = 0.
  - `snap` = 0.
  - RGB = 0.
  - `vga_hs` = `vga_vs` = 1.
  - `vga_blank_n` = 0, `frame_start` = 0, `vga_clk` = 0.
  - `pix_en` = 0.
  - Reset asserted mid-frame forces these values immediately. After release, scan restarts at `h`=0, `v`=0 with `snap`=0, so the first frame is all BG/GRID.

## Timing
- **Pipeline depth.** Two `pix_en` stages: counters → stage 1 (cell index, bit fetch, region flags) → stage 2 (registered RGB, hs, vs, blank_n).
- **Alignment.** Sync and blank are delayed by the same two stages, so all pins stay mutually aligned. The pins lag the counters by exactly 2 pixel ticks.
- **Output hold.** Outputs change only in the `clk` cycle where `pix_en`=1 and are held otherwise.
- **Frame length.** 800 × 525 = 420 000 pixel ticks = 840 000 `clk`.

## Structure
- **Package `vga_pkg`.** Holds the H/V timing constants (active, front porch, sync, back porch, total) and the default colour constants.
- **Sub-module `vga_timing_gen`.** Contains `pix_en`, `h`, `v`, the active flag and the raw sync outputs.
- **Top-level body.** Holds the snapshot register, the cell sub-counters and the two-stage colour pipeline.

## Test plan
- **Reset values.** Assert resetn=0 mid-frame → all outputs take their reset values asynchronously. Release → first `vga_hs` low edge 656+2 pixel ticks later.
- **Sync timing.** Free-run → `vga_hs` low for 96 ticks in every 800. `vga_vs` low for exactly 2 lines (1600 ticks) per 525 lines. `frame_start` period is 840 000 `clk`.
- **Snapshot coherence.** Byte0=0x80 before capture; change to 0x00 at `v`=100 → display stays 0x80 for the rest of that frame and shows 0x00 after the next `frame_start`.
- **Pixel mapping, byte 0.** Byte0=0x80:
  - pixel (81,1) = FG;
  - (80,5) = GRID;
  - (141,1) = BG;
  - (79,1) = black.
- **Pixel mapping, byte 31.** Byte31=0x01, all other bytes 0 → pixel (501,466) = FG, (441,466) = BG, (560,466) = black.
- **Blanking.** Pixel at `h`=640..799 or `v`≥480 → RGB 0 and `vga_blank_n`=0. `vga_sync_n`=0 always.
